// File: rtl/wbcmd_pkg.sv
// Shared definitions for the wbcmd byte-stream command parser: status codes,
// header field positions and the parser state encoding.
package wbcmd_pkg;

    localparam logic [7:0] ST_OK          = 8'h00;
    localparam logic [7:0] ST_BUS_TIMEOUT = 8'h01;
    localparam logic [7:0] ST_BAD_HDR     = 8'h02;

    localparam int unsigned HDR_WRITE_BIT = 7;
    localparam int unsigned HDR_RSVD_MSB  = 6;
    localparam int unsigned HDR_RSVD_LSB  = 2;
    localparam int unsigned HDR_LEN_MSB   = 1;
    localparam int unsigned HDR_LEN_LSB   = 0;

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_WDATA,
        S_ISSUE,
        S_WAIT,
        S_RSP_STAT,
        S_RSP_DATA
    } state_e;

endpackage

// File: rtl/wbcmd_shift.sv
// Byte-wise shift register with a byte counter; bytes enter at the LSB end so
// the first byte ends up most significant, and the MSB byte is the one unloaded.
module wbcmd_shift #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = $clog2(WIDTH / 8 + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] data_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (clear_i) begin
            data_d = '0;
            idx_d  = '0;
        end else if (load_i) begin
            data_d = load_data_i;
            idx_d  = '0;
        end else if (shift_i) begin
            data_d = {data_q[WIDTH-9:0], byte_i};
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign data_o = data_q;
    assign idx_o  = idx_q;

endmodule

// File: rtl/wbcmd_parser.sv
// Framed read/write command parser in front of wishbone_master: collects a
// header/address/data frame, issues one transfer, returns status and read data.
module wbcmd_parser
    import wbcmd_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned DATA_BYTES    = 2,
    parameter int unsigned MAX_PAYLOAD   = 2,
    parameter int unsigned IDLE_TIMEOUT  = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [7:0]                          rx_data_i,
    input  logic                                rx_valid_i,
    output logic                                rx_ready_o,
    output logic [7:0]                          tx_data_o,
    output logic                                tx_valid_o,
    input  logic                                tx_ready_i,
    output logic [ADDRESS_WIDTH-1:0]            transfer_address_o,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0]   payload_o,
    input  logic [MAX_PAYLOAD*DATA_WIDTH-1:0]   payload_i,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]    payload_length_o,
    output logic                                start_read_o,
    output logic                                start_write_o,
    input  logic                                read_busy_i,
    input  logic                                write_busy_i,
    input  logic                                completed_i,
    input  logic                                timeout_i
);

    localparam int unsigned ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam int unsigned PAY_W      = MAX_PAYLOAD * DATA_WIDTH;
    localparam int unsigned RX_W       = ADDRESS_WIDTH + PAY_W;
    localparam int unsigned LEN_W      = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned RX_IDX_W   = $clog2(RX_W / 8 + 1);
    localparam int unsigned TX_IDX_W   = $clog2(PAY_W / 8 + 1);
    localparam int unsigned CNT_W      = $clog2(IDLE_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [7:0]         status_q, status_d;
    logic [CNT_W-1:0]   idle_q, idle_d;

    logic [RX_W-1:0]     rx_word;
    logic [RX_IDX_W-1:0] rx_idx;
    logic [PAY_W-1:0]    tx_word, tx_load_data;
    logic [TX_IDX_W-1:0] tx_idx;
    logic [RX_W-1:0]     addr_shifted, word_shifted;

    logic        rx_fire, tx_fire, master_idle, hdr_bad, rx_last, tx_last;
    logic [1:0]  hdr_len;
    int unsigned frame_bytes;

    assign rx_ready_o  = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign tx_valid_o  = (state_q == S_RSP_STAT) || (state_q == S_RSP_DATA);
    assign rx_fire     = rx_valid_i & rx_ready_o;
    assign tx_fire     = tx_valid_o & tx_ready_i;
    assign master_idle = !read_busy_i && !write_busy_i;

    // Start is gated by the live busy inputs so it can never overlap a busy master.
    assign start_read_o  = (state_q == S_ISSUE) && master_idle && !is_write_q;
    assign start_write_o = (state_q == S_ISSUE) && master_idle && is_write_q;

    assign hdr_len     = rx_data_i[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_bad     = (rx_data_i[HDR_RSVD_MSB:HDR_RSVD_LSB] != '0) || (hdr_len == 2'd0)
                         || (32'(hdr_len) > MAX_PAYLOAD);
    assign frame_bytes = ADDR_BYTES + 32'(length_q) * DATA_BYTES;
    assign rx_last     = (32'(rx_idx) + 1) ==
                         ((state_q == S_ADDR) ? ADDR_BYTES : frame_bytes);
    assign tx_last     = (32'(tx_idx) + 1) == 32'(length_q) * DATA_BYTES;

    wbcmd_shift #(.WIDTH(RX_W)) u_rx_shift (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     ((state_q == S_HDR) && rx_fire),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (((state_q == S_ADDR) || (state_q == S_WDATA)) && rx_fire),
        .byte_i      (rx_data_i),
        .data_o      (rx_word),
        .idx_o       (rx_idx)
    );

    wbcmd_shift #(.WIDTH(PAY_W)) u_tx_shift (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (1'b0),
        .load_i      ((state_q == S_WAIT) && completed_i && !timeout_i),
        .load_data_i (tx_load_data),
        .shift_i     ((state_q == S_RSP_DATA) && tx_fire),
        .byte_i      (8'h00),
        .data_o      (tx_word),
        .idx_o       (tx_idx)
    );

    // The rx register holds address then data words, word 0 highest; unpack by length.
    always_comb begin
        tx_load_data = '0;
        payload_o    = '0;
        word_shifted = '0;
        addr_shifted = rx_word >> (is_write_q ? 32'(length_q) * DATA_WIDTH : 0);
        for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
            tx_load_data[(MAX_PAYLOAD-1-k)*DATA_WIDTH +: DATA_WIDTH] =
                payload_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (is_write_q && (k < 32'(length_q))) begin
                word_shifted = rx_word >> ((32'(length_q) - 1 - k) * DATA_WIDTH);
                payload_o[k*DATA_WIDTH +: DATA_WIDTH] = word_shifted[DATA_WIDTH-1:0];
            end
        end
    end

    assign transfer_address_o = addr_shifted[ADDRESS_WIDTH-1:0];
    assign payload_length_o   = length_q;

    always_comb begin
        case (state_q)
            S_RSP_STAT: tx_data_o = status_q;
            S_RSP_DATA: tx_data_o = tx_word[PAY_W-1 -: 8];
            default:    tx_data_o = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        length_d   = length_q;
        status_d   = status_q;
        idle_d     = '0;
        case (state_q)
            S_HDR: begin
                if (rx_fire) begin
                    is_write_d = rx_data_i[HDR_WRITE_BIT];
                    length_d   = LEN_W'(hdr_len);
                    if (hdr_bad) begin
                        status_d = ST_BAD_HDR;
                        state_d  = S_RSP_STAT;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR, S_WDATA: begin
                if (rx_fire) begin
                    if (rx_last) begin
                        state_d = ((state_q == S_ADDR) && is_write_q) ? S_WDATA : S_ISSUE;
                    end
                end else if (idle_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_d = S_HDR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (master_idle) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timeout_i) begin
                    status_d = ST_BUS_TIMEOUT;
                    state_d  = S_RSP_STAT;
                end else if (completed_i) begin
                    status_d = ST_OK;
                    state_d  = S_RSP_STAT;
                end
            end
            S_RSP_STAT: begin
                if (tx_fire) state_d = (!is_write_q && (status_q == ST_OK)) ? S_RSP_DATA : S_HDR;
            end
            S_RSP_DATA: begin
                if (tx_fire && tx_last) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_HDR;
            is_write_q <= 1'b0;
            length_q   <= '0;
            status_q   <= 8'h00;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            length_q   <= length_d;
            status_q   <= status_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: tb/tb_wbcmd_parser.sv
// Directed bench for wbcmd_parser: a frame-level model predicts start pulses and
// response bytes, and one negedge process checks the DUT against it every cycle.
module tb_wbcmd_parser;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;
    logic [AW-1:0] addr;
    logic [MP*DW-1:0] pay_out;
    logic [MP*DW-1:0] pay_in = '0;
    logic [1:0]    plen;
    logic          sr, sw;
    logic          mrbusy = 1'b0, mwbusy = 1'b0, completed = 1'b0, timeout = 1'b0;
    logic          ext_busy = 1'b0;
    logic          rbusy_w, wbusy_w;

    always #5 clk = ~clk;
    assign rbusy_w = mrbusy | ext_busy;
    assign wbusy_w = mwbusy;

    wbcmd_parser #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DATA_BYTES    (2),
        .MAX_PAYLOAD   (MP),
        .IDLE_TIMEOUT  (1024)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_n),
        .rx_data_i          (rx_data),
        .rx_valid_i         (rx_valid),
        .rx_ready_o         (rx_ready),
        .tx_data_o          (tx_data),
        .tx_valid_o         (tx_valid),
        .tx_ready_i         (tx_ready),
        .transfer_address_o (addr),
        .payload_o          (pay_out),
        .payload_i          (pay_in),
        .payload_length_o   (plen),
        .start_read_o       (sr),
        .start_write_o      (sw),
        .read_busy_i        (rbusy_w),
        .write_busy_i       (wbusy_w),
        .completed_i        (completed),
        .timeout_i          (timeout)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] pay;
        int          len;
    } start_t;

    int          checks = 0;
    int          failures = 0;
    int          n_starts = 0;
    start_t      exp_start[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [7:0]  lit_q[$];
    logic [7:0]  fr[$];
    int          outcome = 0;      // 0 completed, 1 timeout, 2 both together
    logic [31:0] rd_words = '0;
    bit          hang = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_got(input string name, input logic [7:0] lit[$]);
        check({name, "_count"}, 64'(got_tx.size()), 64'(lit.size()));
        for (int i = 0; i < lit.size() && i < got_tx.size(); i++)
            check({name, "_byte"}, 64'(got_tx[i]), 64'(lit[i]));
    endtask

    // Frame rules applied directly: bad header -> 0x02; otherwise one start
    // expectation and the status/read-data bytes the master outcome implies.
    task automatic model_frame(input logic [7:0] f[$]);
        logic [7:0] hdr;
        int         len;
        bit         bad;
        start_t     s;
        hdr = f[0];
        len = int'(hdr[1:0]);
        bad = (hdr[6:2] != 5'd0) || (len == 0) || (len > MP);
        if (bad) begin
            exp_tx.push_back(8'h02);
        end else begin
            s.wr   = hdr[7];
            s.addr = {f[1], f[2]};
            s.pay  = '0;
            s.len  = len;
            if (s.wr)
                for (int k = 0; k < len; k++) s.pay[k*DW +: DW] = {f[3+2*k], f[4+2*k]};
            exp_start.push_back(s);
            if (!hang) begin
                if (outcome != 0) begin
                    exp_tx.push_back(8'h01);
                end else begin
                    exp_tx.push_back(8'h00);
                    if (!s.wr)
                        for (int k = 0; k < len; k++) begin
                            exp_tx.push_back(rd_words[k*DW+8 +: 8]);
                            exp_tx.push_back(rd_words[k*DW +: 8]);
                        end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rx_accept_bound", 64'(n < 2000), 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_start.size() != 0) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_bound", 64'(n < 5000), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
        check({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, "_tx_data"},  64'(tx_data),  64'd0);
        check({tag, "_starts"},   64'({sr, sw}), 64'd0);
        check({tag, "_addr"},     64'(addr),     64'd0);
        check({tag, "_payload"},  64'(pay_out),  64'd0);
        check({tag, "_len"},      64'(plen),     64'd0);
    endtask

    // Bus master stand-in: busy after a start, then completion/timeout 3 cycles later.
    bit m_wr;
    always begin
        @(negedge clk);
        if (rst_n && (sr || sw) && !hang) begin
            m_wr = sw;
            @(posedge clk); #1;
            if (m_wr) mwbusy = 1'b1; else mrbusy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            pay_in    = rd_words;
            completed = (outcome != 1);
            timeout   = (outcome != 0);
            @(posedge clk); #1;
            completed = 1'b0;
            timeout   = 1'b0;
            mrbusy    = 1'b0;
            mwbusy    = 1'b0;
        end
    end

    logic [7:0] prev_tx;
    bit         prev_stall = 1'b0;
    start_t     cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 64'(tx_valid), 64'd1);
                check("tx_hold_data", 64'(tx_data), 64'(prev_tx));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_tx    = tx_data;
            check("ready_valid_exclusive", 64'(rx_ready & tx_valid), 64'd0);
            if (sr || sw) begin
                n_starts++;
                check("start_while_busy", 64'(rbusy_w | wbusy_w), 64'd0);
                check("start_both", 64'(sr & sw), 64'd0);
                check("start_expected", 64'(exp_start.size() != 0), 64'd1);
                if (exp_start.size() != 0) begin
                    cur = exp_start.pop_front();
                    check("start_is_write", 64'(sw), 64'(cur.wr));
                    check("start_addr", 64'(addr), 64'(cur.addr));
                    check("start_len", 64'(plen), 64'(cur.len));
                    if (cur.wr)
                        for (int k = 0; k < cur.len; k++)
                            check("start_payload", 64'(pay_out[k*DW +: DW]), 64'(cur.pay[k*DW +: DW]));
                end
            end
            if (tx_valid && tx_ready) begin
                got_tx.push_back(tx_data);
                check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    int n0;
    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 0x2211 to 0x3000
        got_tx.delete();
        fr = {8'h81, 8'h30, 8'h00, 8'h22, 8'h11};
        model_frame(fr);
        send_frame(fr);
        check("wr_start_latency", 64'(sw), 64'd1);
        check("wr_addr_lit", 64'(addr), 64'h3000);
        check("wr_word0_lit", 64'(pay_out[15:0]), 64'h2211);
        check("wr_len_lit", 64'(plen), 64'd1);
        wait_drain();
        lit_q = {8'h00};
        check_got("wr_resp", lit_q);

        // Two-word read from 0x1000
        got_tx.delete();
        rd_words = {16'h2222, 16'h1111};
        fr = {8'h02, 8'h10, 8'h00};
        model_frame(fr);
        send_frame(fr);
        check("rd_start_latency", 64'(sr), 64'd1);
        wait_drain();
        lit_q = {8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
        check_got("rd_resp", lit_q);

        // Bad headers back to back, then a valid read
        got_tx.delete();
        n0 = n_starts;
        rd_words = {16'hBEEF, 16'hCAFE};
        foreach (lit_q[i]) ;
        fr = {8'h03}; model_frame(fr); send_frame(fr);
        fr = {8'h80}; model_frame(fr); send_frame(fr);
        fr = {8'h44}; model_frame(fr); send_frame(fr);
        fr = {8'h02, 8'h12, 8'h34}; model_frame(fr); send_frame(fr);
        wait_drain();
        check("bad_hdr_starts", 64'(n_starts - n0), 64'd1);
        lit_q = {8'h02, 8'h02, 8'h02, 8'h00, 8'hCA, 8'hFE, 8'hBE, 8'hEF};
        check_got("bad_hdr_resp", lit_q);

        // Completed and timeout together: timeout status, no data
        got_tx.delete();
        outcome = 2;
        fr = {8'h01, 8'h20, 8'h00};
        model_frame(fr);
        send_frame(fr);
        wait_drain();
        lit_q = {8'h01};
        check_got("both_resp", lit_q);
        outcome = 0;

        // Idle timeout discards a partial frame silently
        got_tx.delete();
        n0 = n_starts;
        send_byte(8'h81);
        send_byte(8'h30);
        repeat (1024) @(posedge clk);
        #1;
        check("idle_no_start", 64'(n_starts - n0), 64'd0);
        check("idle_no_resp", 64'(got_tx.size()), 64'd0);
        fr = {8'h81, 8'h40, 8'h01, 8'hAB, 8'hCD};
        model_frame(fr);
        send_frame(fr);
        wait_drain();
        lit_q = {8'h00};
        check_got("idle_after_resp", lit_q);

        // A gap just under the idle limit keeps the frame alive
        got_tx.delete();
        rd_words = {16'h0000, 16'h5566};
        fr = {8'h01, 8'h10, 8'h77};
        model_frame(fr);
        send_byte(8'h01);
        send_byte(8'h10);
        repeat (1022) @(posedge clk);
        #1;
        send_byte(8'h77);
        wait_drain();
        lit_q = {8'h00, 8'h55, 8'h66};
        check_got("idle_gap_resp", lit_q);

        // Master busy holds off the start pulse
        got_tx.delete();
        ext_busy = 1'b1;
        fr = {8'h81, 8'h50, 8'h00, 8'h12, 8'h34};
        model_frame(fr);
        send_frame(fr);
        n0 = n_starts;
        repeat (5) @(posedge clk);
        #1;
        check("busy_hold_start", 64'(n_starts - n0), 64'd0);
        ext_busy = 1'b0;
        wait_drain();
        lit_q = {8'h00};
        check_got("busy_resp", lit_q);

        // Response backpressure mid-read
        got_tx.delete();
        rd_words = {16'h5A5A, 16'hC33C};
        fr = {8'h02, 8'h60, 8'h00};
        model_frame(fr);
        send_frame(fr);
        n0 = 0;
        while (got_tx.size() < 2 && n0 < 200) begin
            @(posedge clk); #1;
            n0++;
        end
        check("bp_reach_bound", 64'(n0 < 200), 64'd1);
        tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_drain();
        lit_q = {8'h00, 8'hC3, 8'h3C, 8'h5A, 8'h5A};
        check_got("bp_resp", lit_q);

        // Reset while waiting on the master
        got_tx.delete();
        hang = 1'b1;
        fr = {8'h01, 8'h70, 8'h00};
        model_frame(fr);
        send_frame(fr);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        hang  = 1'b0;
        check("midreset_no_resp", 64'(got_tx.size()), 64'd0);
        rd_words = {16'h0000, 16'h0F0F};
        fr = {8'h01, 8'h71, 8'h00};
        model_frame(fr);
        send_frame(fr);
        wait_drain();
        lit_q = {8'h00, 8'h0F, 8'h0F};
        check_got("post_reset_resp", lit_q);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
